data_ext: RTL

DATA_EXT -- requirements
Module: data_ext

---
 rtl/data_ext_pkg.sv | 17 +
 rtl/ext_core.sv | 58 +++++
 rtl/data_ext.sv | 91 +++++++++
 3 files changed

// File: rtl/data_ext_pkg.sv
// Shared CPU definitions: extension op encodings used by the decoder and data_ext.
package data_ext_pkg;

   localparam int OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_ZERO = 3'd0,
      OP_SIGN = 3'd1,
      OP_LUI  = 3'd2,
      OP_BOFF = 3'd3,
      OP_LB   = 3'd4,
      OP_LBU  = 3'd5,
      OP_LH   = 3'd6,
      OP_LHU  = 3'd7
   } ext_op_e;

endpackage

// File: rtl/ext_core.sv
// Pure immediate/load-data extension: (op, data, off) -> (res, err).
// Combinational, zero latency; no flow control.
// Misaligned or word-crossing halfword loads flag err and force res to zero.
module ext_core
   import data_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int OFF_W = $clog2(OUT_W/8)
) (
   input  logic [OP_W-1:0]  op,
   input  logic [OUT_W-1:0] data,
   input  logic [OFF_W-1:0] off,
   output logic [OUT_W-1:0] res,
   output logic             err
);

   localparam int NB = OUT_W/8;

   logic [IN_W-1:0]  imm;
   logic [OUT_W-1:0] zext;
   logic [OUT_W-1:0] sext;
   logic [7:0]       byte_v;
   logic [15:0]      half_v;
   logic             half_bad;

   assign imm      = data[IN_W-1:0];
   assign zext     = {{(OUT_W-IN_W){1'b0}}, imm};
   assign sext     = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
   assign byte_v   = 8'(data >> {off, 3'b000});
   assign half_v   = 16'(data >> {off, 3'b000});
   // Halfword must be 2-byte aligned and must end inside the word.
   assign half_bad = off[0] || (int'(off) > NB-2);

   always_comb begin
      res = '0;
      err = 1'b0;
      case (ext_op_e'(op))
         OP_ZERO: res = zext;
         OP_SIGN: res = sext;
         OP_LUI:  res = {imm, {(OUT_W-IN_W){1'b0}}};
         OP_BOFF: res = sext << 2;
         OP_LB:   res = {{(OUT_W-8){byte_v[7]}}, byte_v};
         OP_LBU:  res = {{(OUT_W-8){1'b0}}, byte_v};
         OP_LH, OP_LHU: begin
            if (half_bad) begin
               err = 1'b1;
            end else if (ext_op_e'(op) == OP_LH) begin
               res = {{(OUT_W-16){half_v[15]}}, half_v};
            end else begin
               res = {{(OUT_W-16){1'b0}}, half_v};
            end
         end
         default: res = '0;
      endcase
   end

endmodule

// File: rtl/data_ext.sv
// Extension unit wrapped in a 2-entry output register + skid buffer.
// Latency 1 cycle; sustains 1 result/cycle while out_ready is high.
// in_ready is registered (!skid_full) and never depends combinationally on out_ready.
module data_ext
   import data_ext_pkg::*;
#(
   parameter int IN_W  = 16,
   parameter int OUT_W = 32,
   parameter int OFF_W = $clog2(OUT_W/8)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [OP_W-1:0]  in_op,
   input  logic [OUT_W-1:0] in_data,
   input  logic [OFF_W-1:0] in_off,
   output logic             out_valid,
   output logic [OUT_W-1:0] out_data,
   output logic             out_err,
   input  logic             out_ready
);

   logic [OUT_W-1:0] core_res;
   logic             core_err;
   logic             xfer;
   logic             stall;
   logic             skid_nxt;
   logic             rdy_q;
   logic             out_vld_q;
   logic [OUT_W-1:0] out_dat_q;
   logic             out_err_q;
   logic             skid_vld_q;
   logic [OUT_W-1:0] skid_dat_q;
   logic             skid_err_q;

   ext_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .OFF_W (OFF_W)
   ) u_core (
      .op   (in_op),
      .data (in_data),
      .off  (in_off),
      .res  (core_res),
      .err  (core_err)
   );

   assign xfer  = in_valid && rdy_q;
   assign stall = out_vld_q && !out_ready;
   // Skid stays (or becomes) occupied only while the output register is stalled.
   assign skid_nxt = stall && (skid_vld_q || xfer);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_q      <= 1'b0;
         out_vld_q  <= 1'b0;
         out_dat_q  <= '0;
         out_err_q  <= 1'b0;
         skid_vld_q <= 1'b0;
         skid_dat_q <= '0;
         skid_err_q <= 1'b0;
      end else begin
         if (!stall) begin
            if (skid_vld_q) begin
               out_dat_q  <= skid_dat_q;
               out_err_q  <= skid_err_q;
               out_vld_q  <= 1'b1;
               skid_vld_q <= 1'b0;
            end else if (xfer) begin
               out_dat_q <= core_res;
               out_err_q <= core_err;
               out_vld_q <= 1'b1;
            end else begin
               out_vld_q <= 1'b0;
            end
         end else if (xfer) begin
            skid_dat_q <= core_res;
            skid_err_q <= core_err;
            skid_vld_q <= 1'b1;
         end
         rdy_q <= !skid_nxt;
      end
   end

   assign in_ready  = rdy_q;
   assign out_valid = out_vld_q;
   assign out_data  = out_dat_q;
   assign out_err   = out_err_q;

endmodule
